// File: rtl/mode7_pkg.sv
// Shared constants and FSM state type for the Mode 7 coordinate generator.
package mode7_pkg;

  // 16.8 signed fixed point
  localparam int unsigned FpWidth = 24;
  localparam int unsigned FpFrac  = 8;

  // Texture map is 1024 x 1024 texels
  localparam int unsigned TexSize = 1024;
  localparam int unsigned TexBits = $clog2(TexSize);

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StSum,
    StPixel,
    StDone
  } state_e;

endpackage

// File: rtl/multiply_fp.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC, low W bits kept.
module multiply_fp #(
  parameter int unsigned W    = 24,
  parameter int unsigned FRAC = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] full;

  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};
  assign full  = a_ext * b_ext;
  assign p     = W'(full >>> FRAC);

endmodule

// File: rtl/mode7_coord_gen.sv
// Mode 7 affine coordinate generator: per-line base via one shared multiplier,
// per-pixel stepping by matrix terms, valid/ready output to the texture fetch.
module mode7_coord_gen
  import mode7_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned V_ACTIVE = 224,
  parameter int unsigned W        = FpWidth,
  parameter int unsigned FRAC     = FpFrac
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] mat_a,
  input  logic [W-1:0] mat_b,
  input  logic [W-1:0] mat_c,
  input  logic [W-1:0] mat_d,
  input  logic [W-1:0] org_x,
  input  logic [W-1:0] org_y,
  input  logic [W-1:0] scr_h,
  input  logic [W-1:0] scr_v,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [9:0]   tex_x,
  output logic [9:0]   tex_y,
  output logic         oob,
  output logic [8:0]   pix_x,
  output logic [7:0]   pix_y,
  output logic         busy,
  output logic         frame_done
);

  localparam logic [8:0] LastX = 9'(H_ACTIVE - 1);
  localparam logic [7:0] LastY = 8'(V_ACTIVE - 1);

  state_e state_q, state_d;
  logic [1:0]   idx_q;
  logic [8:0]   sx_q;
  logic [7:0]   sy_q;
  logic [W-1:0] a_q, b_q, c_q, d_q, ox_q, oy_q, sh_q, sv_q;
  logic [W-1:0] p_q [4];
  logic [W-1:0] u_q, v_q;

  logic [W-1:0] dx0, dy, sy_fp;
  logic [W-1:0] mul_a, mul_b, prod;
  logic         hs;

  // Line base operands: dx at sx = 0, dy for the current line
  assign sy_fp = W'({sy_q, {FRAC{1'b0}}});
  assign dx0   = sh_q - ox_q;
  assign dy    = sy_fp + sv_q - oy_q;
  assign hs    = out_valid & out_ready;

  // Operand mux for the single time-shared multiplier
  always_comb begin
    mul_a = a_q;
    mul_b = dx0;
    unique case (idx_q)
      2'd0: begin mul_a = a_q; mul_b = dx0; end
      2'd1: begin mul_a = b_q; mul_b = dy;  end
      2'd2: begin mul_a = c_q; mul_b = dx0; end
      2'd3: begin mul_a = d_q; mul_b = dy;  end
      default: ;
    endcase
  end

  multiply_fp #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_d    = state_q;
    out_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StMul;
      end
      StMul: begin
        busy = 1'b1;
        if (idx_q == 2'd3) state_d = StSum;
      end
      StSum: begin
        busy    = 1'b1;
        state_d = StPixel;
      end
      StPixel: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && sx_q == LastX) state_d = (sy_q == LastY) ? StDone : StMul;
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: shadow capture, product registers, accumulators and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      ox_q  <= '0;
      oy_q  <= '0;
      sh_q  <= '0;
      sv_q  <= '0;
      p_q   <= '{default: '0};
      u_q   <= '0;
      v_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= mat_a;
            b_q   <= mat_b;
            c_q   <= mat_c;
            d_q   <= mat_d;
            ox_q  <= org_x;
            oy_q  <= org_y;
            sh_q  <= scr_h;
            sv_q  <= scr_v;
            sy_q  <= '0;
            sx_q  <= '0;
            idx_q <= '0;
          end
        end
        StMul: begin
          p_q[idx_q] <= prod;
          idx_q      <= idx_q + 2'd1;
        end
        StSum: begin
          u_q  <= p_q[0] + p_q[1] + ox_q;
          v_q  <= p_q[2] + p_q[3] + oy_q;
          sx_q <= '0;
        end
        StPixel: begin
          if (hs) begin
            // Exact: A*(dx + 1.0) == A*dx + A because the extra term has no fraction to drop
            u_q  <= u_q + a_q;
            v_q  <= v_q + c_q;
            sx_q <= sx_q + 9'd1;
            if (sx_q == LastX && sy_q != LastY) sy_q <= sy_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tex_x = u_q[FRAC +: TexBits];
  assign tex_y = v_q[FRAC +: TexBits];
  assign oob   = (|u_q[W-1:FRAC+TexBits]) | (|v_q[W-1:FRAC+TexBits]);
  assign pix_x = sx_q;
  assign pix_y = sy_q;

endmodule

// File: tb/tb_mode7_coord_gen.sv
// Self-checking bench: table-driven frame configs, scoreboard of model pixels, spot values.
module tb_mode7_coord_gen;

  localparam int unsigned H = 256;
  localparam int unsigned V = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] mat_a = '0, mat_b = '0, mat_c = '0, mat_d = '0;
  logic [23:0] org_x = '0, org_y = '0, scr_h = '0, scr_v = '0;
  logic        out_valid, oob, busy, frame_done;
  logic [9:0]  tex_x, tex_y;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;

  mode7_coord_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .W        (24),
    .FRAC     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mat_a      (mat_a),
    .mat_b      (mat_b),
    .mat_c      (mat_c),
    .mat_d      (mat_d),
    .org_x      (org_x),
    .org_y      (org_y),
    .scr_h      (scr_h),
    .scr_v      (scr_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .tex_x      (tex_x),
    .tex_y      (tex_y),
    .oob        (oob),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a, b, c, d, ox, oy, sh, sv;
    bit          rnd;
  } cfg_t;

  typedef struct {
    int cfg;
    int sx, sy;
    int tx, ty;
    int oob;
  } spot_t;

  typedef struct packed {
    logic [8:0] px;
    logic [7:0] py;
    logic [9:0] tx;
    logic [9:0] ty;
    logic       oob;
  } exp_t;

  cfg_t  cfgs [5];
  spot_t spots [12];
  exp_t  sb [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_edge = 0;
  int done_cnt = 0;
  int cur_cfg = 0;
  bit rnd_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] mulfp(input logic [23:0] x, input logic [23:0] y);
    longint prod;
    longint sh;
    prod = longint'($signed(x)) * longint'($signed(y));
    sh   = prod >>> 8;
    return sh[23:0];
  endfunction

  // Direct per-pixel affine evaluation
  function automatic exp_t model(input cfg_t c, input int sx, input int sy);
    logic [23:0] dx, dy, u, v;
    exp_t e;
    dx = (24'(sx) << 8) + c.sh - c.ox;
    dy = (24'(sy) << 8) + c.sv - c.oy;
    u = mulfp(c.a, dx) + mulfp(c.b, dy) + c.ox;
    v = mulfp(c.c, dx) + mulfp(c.d, dy) + c.oy;
    e.px  = 9'(sx);
    e.py  = 8'(sy);
    e.tx  = u[17:8];
    e.ty  = v[17:8];
    e.oob = (u[23:18] != 6'd0) || (v[23:18] != 6'd0);
    return e;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Ready generator: constant or pseudo-random, changed just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_mode ? ($urandom_range(0, 2) == 0 ? 1'b0 : ($urandom_range(0, 1) == 1)) : 1'b1;
  end

  // Output monitor: stall stability, line gap, scoreboard pop and spot values
  initial begin
    logic prev_valid;
    logic prev_ready;
    exp_t prev_data;
    exp_t act;
    exp_t e;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      act = '{px: pix_x, py: pix_y, tx: tex_x, ty: tex_y, oob: oob};
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          chk("stall_valid_held", 64'(out_valid), 64'd1);
          chk("stall_data_held", 64'(act), 64'(prev_data));
        end
        if (out_valid && !prev_valid) chk("line_gap_cycles", 64'(cyc - hs_edge), 64'd5);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 64'(act), 64'd0);
            chk("unexpected_output_flag", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("pixel", 64'(act), 64'(e));
            foreach (spots[i]) begin
              if (spots[i].cfg == cur_cfg && spots[i].sx == int'(pix_x) &&
                  spots[i].sy == int'(pix_y)) begin
                chk("spot_tex_x", 64'(tex_x), 64'(spots[i].tx));
                chk("spot_tex_y", 64'(tex_y), 64'(spots[i].ty));
                chk("spot_oob", 64'(oob), 64'(spots[i].oob));
              end
            end
          end
          if (pix_x == 9'(H - 1)) hs_edge = cyc + 1;
        end
        if (frame_done) done_cnt++;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = act;
      end
    end
  end

  task automatic apply_cfg(input cfg_t c);
    mat_a = c.a; mat_b = c.b; mat_c = c.c; mat_d = c.d;
    org_x = c.ox; org_y = c.oy; scr_h = c.sh; scr_v = c.sv;
  endtask

  task automatic scramble_inputs();
    mat_a = 24'($urandom); mat_b = 24'($urandom); mat_c = 24'($urandom);
    mat_d = 24'($urandom); org_x = 24'($urandom); org_y = 24'($urandom);
    scr_h = 24'($urandom); scr_v = 24'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start   = 1'b1;
    hs_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Load a config, queue its expected pixels and launch the frame
  task automatic begin_frame(input int i);
    cur_cfg  = i;
    rnd_mode = cfgs[i].rnd;
    apply_cfg(cfgs[i]);
    for (int y = 0; y < int'(V); y++)
      for (int x = 0; x < int'(H); x++) sb.push_back(model(cfgs[i], x, y));
    done_cnt = 0;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    scramble_inputs();
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    chk("frame_done_once", 64'(done_cnt), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("busy_after_frame", 64'(busy), 64'd0);
    chk("valid_after_frame", 64'(out_valid), 64'd0);
  endtask

  task automatic wait_pixel(input int y, input int x, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20000) begin
      @(negedge clk);
      n++;
      ok = out_valid && int'(pix_y) == y && int'(pix_x) == x;
    end
    chk("wait_pixel_reached", 64'(ok), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_tex_x"}, 64'(tex_x), 64'd0);
    chk({tag, "_tex_y"}, 64'(tex_y), 64'd0);
    chk({tag, "_oob"}, 64'(oob), 64'd0);
    chk({tag, "_pix_x"}, 64'(pix_x), 64'd0);
    chk({tag, "_pix_y"}, 64'(pix_y), 64'd0);
  endtask

  initial begin
    bit ok;
    // Frame configurations: identity, scale x2, rotate 90, wrap, mixed with backpressure
    cfgs[0] = '{a: 24'h000100, b: 24'h0, c: 24'h0, d: 24'h000100,
                ox: 24'h0, oy: 24'h0, sh: 24'h0, sv: 24'h0, rnd: 1'b0};
    cfgs[1] = '{a: 24'h000200, b: 24'h0, c: 24'h0, d: 24'h000200,
                ox: 24'h0, oy: 24'h0, sh: 24'h0, sv: 24'h0, rnd: 1'b0};
    cfgs[2] = '{a: 24'h0, b: 24'hFFFF00, c: 24'h000100, d: 24'h0,
                ox: 24'h008000, oy: 24'h008000, sh: 24'h0, sv: 24'h0, rnd: 1'b0};
    cfgs[3] = '{a: 24'h000100, b: 24'h0, c: 24'h0, d: 24'h000100,
                ox: 24'h0, oy: 24'h0, sh: 24'h03FF00, sv: 24'h0, rnd: 1'b0};
    cfgs[4] = '{a: 24'h000180, b: 24'h000040, c: 24'hFFFFC0, d: 24'h000100,
                ox: 24'h004000, oy: 24'h002000, sh: 24'h000A80, sv: 24'hFFFE00, rnd: 1'b1};
    // Hand-derived expected texels
    spots[0]  = '{cfg: 0, sx: 5,   sy: 3,  tx: 5,    ty: 3,  oob: 0};
    spots[1]  = '{cfg: 0, sx: 255, sy: 11, tx: 255,  ty: 11, oob: 0};
    spots[2]  = '{cfg: 1, sx: 0,   sy: 3,  tx: 0,    ty: 6,  oob: 0};
    spots[3]  = '{cfg: 1, sx: 1,   sy: 3,  tx: 2,    ty: 6,  oob: 0};
    spots[4]  = '{cfg: 1, sx: 255, sy: 3,  tx: 510,  ty: 6,  oob: 0};
    spots[5]  = '{cfg: 2, sx: 0,   sy: 0,  tx: 256,  ty: 0,  oob: 0};
    spots[6]  = '{cfg: 2, sx: 5,   sy: 0,  tx: 256,  ty: 5,  oob: 0};
    spots[7]  = '{cfg: 2, sx: 0,   sy: 2,  tx: 254,  ty: 0,  oob: 0};
    spots[8]  = '{cfg: 3, sx: 0,   sy: 0,  tx: 1023, ty: 0,  oob: 0};
    spots[9]  = '{cfg: 3, sx: 1,   sy: 0,  tx: 0,    ty: 0,  oob: 1};
    spots[10] = '{cfg: 2, sx: 200, sy: 0,  tx: 256,  ty: 200, oob: 0};
    spots[11] = '{cfg: 3, sx: 2,   sy: 5,  tx: 1,    ty: 5,  oob: 1};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      begin_frame(i);
      finish_frame();
    end

    // Mid-frame start is ignored, then asynchronous reset during line 10
    begin_frame(0);
    wait_pixel(2, 7, ok);
    scramble_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_pixel(10, 50, ok);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(negedge clk);
    chk("no_frame_done_on_reset", 64'(done_cnt), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);

    // Restart from (0,0) after the reset
    begin_frame(0);
    finish_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
